// File: rtl/shift_register_right_pkg.sv
// rtl/shift_register_right_pkg.sv - shared width constants for the shift-and-add multiplier
package shift_register_right_pkg;

    localparam int DEFAULT_WORD_LENGTH = 2;

    // Partial products span twice the operand width.
    function automatic int double_width(input int word_length);
        return 2 * word_length;
    endfunction

    localparam int DEFAULT_DOUBLE_WIDTH = double_width(DEFAULT_WORD_LENGTH);

endpackage

// File: rtl/shift_register_right.sv
// rtl/shift_register_right.sv - double-width right-shift register with zero-extended parallel load
module shift_register_right
    import shift_register_right_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [WORD_LENGTH-1:0]              parallelInput,
    input  logic                                serialInput,
    input  logic                                load,
    input  logic                                shift,
    output logic                                serialOutput,
    output logic [double_width(WORD_LENGTH)-1:0] parallelOutput
);

    localparam int W2 = double_width(WORD_LENGTH);

    logic [W2-1:0] r_q;
    logic [W2-1:0] r_d;

    // Load outranks shift; the operand always lands zero-extended in the low half.
    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = {{WORD_LENGTH{1'b0}}, parallelInput};
        end else if (shift) begin
            r_d = {serialInput, r_q[W2-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign parallelOutput = r_q;
    assign serialOutput   = r_q[0];

endmodule

// File: tb/tb_shift_register_right.sv
// tb/tb_shift_register_right.sv - self-checking bench for shift_register_right
module tb_shift_register_right;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] parallelInput;
    logic       serialInput;
    logic       load;
    logic       shift;
    logic       serialOutput;
    logic [3:0] parallelOutput;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int mdl       = 0;

    shift_register_right #(.WORD_LENGTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .parallelInput (parallelInput),
        .serialInput   (serialInput),
        .load          (load),
        .shift         (shift),
        .serialOutput  (serialOutput),
        .parallelOutput(parallelOutput)
    );

    always #5 clk = ~clk;

    // Drive one cycle of enables and advance the reference model arithmetically.
    task automatic cycle(input logic l, input logic s, input logic si, input logic [1:0] pi);
        load = l;
        shift = s;
        serialInput = si;
        parallelInput = pi;
        @(posedge clk);
        if (reset) mdl = 0;
        else if (l) mdl = int'(pi);
        else if (s) mdl = (mdl / 2) + (si ? 8 : 0);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load = 1'b0; shift = 1'b0; serialInput = 1'b0; parallelInput = 2'b00;
        #1;
        total_cnt++;
        if (parallelOutput !== 4'b0000 || serialOutput !== 1'b0)
            $display("FAIL reset_initial: got %b/%b want 0000/0", parallelOutput, serialOutput);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl = 0;
        cycle(1'b1, 1'b0, 1'b0, 2'b11);
        total_cnt++;
        if (parallelOutput !== 4'b0011)
            $display("FAIL reset_preload: got %b want 0011", parallelOutput);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        mdl = 0;
        total_cnt++;
        if (parallelOutput !== 4'b0000 || serialOutput !== 1'b0)
            $display("FAIL reset_async: got %b/%b want 0000/0", parallelOutput, serialOutput);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 2'b11);
            total_cnt++;
            if (parallelOutput !== 4'b0000 || serialOutput !== 1'b0)
                $display("FAIL reset_hold_load: got %b/%b want 0000/0", parallelOutput, serialOutput);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    task automatic test_load;
        cycle(1'b1, 1'b0, 1'b0, 2'b01);
        total_cnt++;
        if (parallelOutput !== 4'b0001 || serialOutput !== 1'b1)
            $display("FAIL load: got %b/%b want 0001/1", parallelOutput, serialOutput);
        else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 2'b10);
        total_cnt++;
        if (parallelOutput !== 4'b0001)
            $display("FAIL load_hold: got %b want 0001", parallelOutput);
        else pass_cnt++;
    endtask

    task automatic test_shift_zero;
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0000;
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        total_cnt++;
        if (parallelOutput !== exp_seq[0] || serialOutput !== 1'b0)
            $display("FAIL shift_zero_a: got %b/%b want 0000/0", parallelOutput, serialOutput);
        else pass_cnt++;
        cycle(1'b1, 1'b0, 1'b0, 2'b11);
        for (int i = 1; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b00);
            total_cnt++;
            if (parallelOutput !== exp_seq[i] || serialOutput !== exp_seq[i][0])
                $display("FAIL shift_zero_b%0d: got %b want %b", i, parallelOutput, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_shift_one;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1100; exp_seq[2] = 4'b1110; exp_seq[3] = 4'b1111;
        cycle(1'b1, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'b00);
            total_cnt++;
            if (parallelOutput !== exp_seq[i] || serialOutput !== (i == 3))
                $display("FAIL shift_one_%0d: got %b/%b want %b/%0d", i, parallelOutput, serialOutput, exp_seq[i], (i == 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_priority;
        cycle(1'b1, 1'b1, 1'b1, 2'b10);
        total_cnt++;
        if (parallelOutput !== 4'b0010 || serialOutput !== 1'b0)
            $display("FAIL priority: got %b/%b want 0010/0", parallelOutput, serialOutput);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 1'b0, 2'b11);
        cycle(1'b0, 1'b1, 1'b1, 2'b00);
        total_cnt++;
        if (parallelOutput !== 4'b1001)
            $display("FAIL mid_shift: got %b want 1001", parallelOutput);
        else pass_cnt++;
        #3;
        reset = 1'b1;
        #1;
        mdl = 0;
        total_cnt++;
        if (parallelOutput !== 4'b0000)
            $display("FAIL mid_reset: got %b want 0000", parallelOutput);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 2'b01);
        total_cnt++;
        if (parallelOutput !== 4'b0001)
            $display("FAIL mid_reload: got %b want 0001", parallelOutput);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset = 1'b1;
                mdl = 0;
                cycle(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
                reset = 1'b0;
            end else begin
                cycle(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 2'($urandom));
            end
            exp_v = 4'(mdl);
            total_cnt++;
            if (parallelOutput !== exp_v || serialOutput !== exp_v[0])
                $display("FAIL random_%0d: got %b/%b want %b/%b", i, parallelOutput, serialOutput, exp_v, exp_v[0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_shift_zero;
        test_shift_one;
        test_priority;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
